multicycle_control_fsm: RTL

- Moore-style sequencer for the multicycle MIPS datapath. Steps each instruction through fetch, decode, execute, memory and writeback, one state per clock.
- Sits beside the shared instruction/data memory, ALU and register file. Drives their selects and write enables.
- Stalls on a memory-ready handshake, retires instructions into a counter and flags unsupported opcodes.

---
 rtl/multicycle_control_fsm.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback,
// with memory-ready stalls, a retired-instruction counter and a sticky illegal-opcode flag.
module multicycle_control_fsm #(
  parameter logic [5:0]  OP_RTYPE = 6'h00,
  parameter logic [5:0]  OP_LW    = 6'h23,
  parameter logic [5:0]  OP_SW    = 6'h2B,
  parameter logic [5:0]  OP_BEQ   = 6'h04,
  parameter logic [5:0]  OP_ADDI  = 6'h08,
  parameter logic [5:0]  OP_J     = 6'h02,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [5:0]       op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  logic             boundary;
  logic             retire;
  logic             set_illegal;
  logic             latch_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_op) begin
        op_q <= opcode;
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Final states and illegal decodes share one exit: FETCH or IDLE depending on run.
  always_comb begin
    state_d     = state_q;
    boundary    = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    latch_op    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        latch_op = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default: begin
            set_illegal = 1'b1;
            boundary    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          retire   = 1'b1;
          boundary = 1'b1;
        end
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        retire   = 1'b1;
        boundary = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (boundary) begin
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC only load on the cycle the fetch actually completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;
  assign retired    = retired_q;

endmodule
